pulse_train_gen: RTL

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_train_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits a train of pulses of programmable width and period,
// running continuously, for a programmed burst count, or once.
//
// Ports:
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   start_i      start request, honoured only while idle
//   stop_i       abort request, returns to idle without a done strobe
//   mode_i       00 continuous, 01 burst, 10/11 one-shot
//   period_i     pulse period in clk cycles
//   width_i      pulse high time in clk cycles
//   burst_i      number of pulses in burst mode
//   pulse_o      registered pulse output
//   busy_o       high whenever the FSM is not idle
//   done_o       one-cycle strobe on normal completion
//   pulse_cnt_o  pulses started since the last accepted start
module pulse_train_gen #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] burst_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pulse_cnt_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHigh = 2'd1;
  localparam logic [1:0] StLow  = 2'd2;

  localparam logic [CNT_W-1:0] OneN = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   OneW = {{CNT_W{1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [CNT_W:0]   cnt_q, cnt_d;      // cycles left in the current phase
  logic [CNT_W:0]   wid_q, wid_d;      // latched effective width
  logic [CNT_W:0]   low_q, low_d;      // latched low time (P - W)
  logic [CNT_W-1:0] rem_q, rem_d;      // pulses still to be started
  logic             cont_q, cont_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;

  // Effective parameters, computed one bit wider so W+1 cannot overflow.
  logic [CNT_W:0]   w_eff, p_eff, low_eff;
  logic [CNT_W-1:0] b_eff;

  always_comb begin
    w_eff   = (width_i == '0) ? OneW : {1'b0, width_i};
    p_eff   = ({1'b0, period_i} > w_eff) ? {1'b0, period_i} : (w_eff + OneW);
    low_eff = p_eff - w_eff;
    b_eff   = ((mode_i == 2'b01) && (burst_i != '0)) ? burst_i : OneN;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wid_d   = wid_q;
    low_d   = low_q;
    rem_d   = rem_q;
    cont_d  = cont_q;
    pcnt_d  = pcnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          // One-cycle lead-in in LOW so the first pulse rises on the edge
          // after the accepting edge, with busy already high.
          state_d = StLow;
          cnt_d   = OneW;
          wid_d   = w_eff;
          low_d   = low_eff;
          rem_d   = b_eff;
          cont_d  = (mode_i == 2'b00);
          pcnt_d  = '0;
        end
      end
      StHigh: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (cnt_q == OneW) begin
          state_d = StLow;
          cnt_d   = low_q;
        end else begin
          cnt_d = cnt_q - OneW;
        end
      end
      StLow: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (cnt_q == OneW) begin
          if (cont_q || (rem_q != '0)) begin
            state_d = StHigh;
            cnt_d   = wid_q;
            pcnt_d  = pcnt_q + OneN;
            if (!cont_q) rem_d = rem_q - OneN;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - OneW;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    pulse_d = (state_d == StHigh);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wid_q   <= '0;
      low_q   <= '0;
      rem_q   <= '0;
      cont_q  <= 1'b0;
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wid_q   <= wid_d;
      low_q   <= low_d;
      rem_q   <= rem_d;
      cont_q  <= cont_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign pulse_o     = pulse_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign pulse_cnt_o = pcnt_q;

endmodule
